// File: rtl/vid_st_pkg.sv
// Shared types and constants for the video stream frame buffer writer and raster reader.
package vid_st_pkg;

  localparam int unsigned FB_WIDTH     = 320;
  localparam int unsigned FB_HEIGHT    = 240;
  localparam int unsigned FRAME_PIXELS = FB_WIDTH * FB_HEIGHT;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SHORT   = 2'b01;
  localparam logic [1:0] ERR_LONG    = 2'b10;
  localparam logic [1:0] ERR_RESTART = 2'b11;

  typedef enum logic [1:0] {StIdle, StActive, StDiscard} state_e;

  // Keep the top 4 bits of each 10-bit channel.
  function automatic logic [11:0] rgb30_to_rgb444(input logic [29:0] d);
    return {d[29:26], d[19:16], d[9:6]};
  endfunction

endpackage

// File: rtl/vid_st_fb_writer.sv
// Avalon-ST video sink writing RGB444 pixels into the frame buffer, with framing checks.
module vid_st_fb_writer
  import vid_st_pkg::*;
#(
  parameter int unsigned WIDTH  = FB_WIDTH,
  parameter int unsigned HEIGHT = FB_HEIGHT,
  parameter int unsigned DATA_W = 30,
  parameter int unsigned PIX_W  = 12,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,
  input  logic              snk_sop,
  input  logic              snk_eop,
  input  logic              hold,
  output logic [ADDR_W-1:0] wraddress,
  output logic [PIX_W-1:0]  wrdata,
  output logic              wren,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic              busy
);

  localparam int unsigned       Pixels  = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(Pixels - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              disc_first_q, disc_first_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;

  logic              accept;
  logic              take;
  logic              restart;
  logic [ADDR_W-1:0] pos;

  assign snk_ready = ~reset;
  assign accept    = snk_valid & snk_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    disc_first_d = disc_first_q;
    wren_d       = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    code_d       = code_q;
    take         = 1'b0;
    restart      = 1'b0;
    pos          = '0;

    unique case (state_q)
      StIdle: begin
        if (accept && snk_sop && !hold) begin
          take = 1'b1;
        end
      end
      StActive: begin
        if (accept) begin
          take    = 1'b1;
          restart = snk_sop;
          pos     = snk_sop ? '0 : cnt_q;
        end
      end
      StDiscard: begin
        if (accept) begin
          if (disc_first_q) begin
            err_d  = 1'b1;
            code_d = ERR_LONG;
          end
          disc_first_d = 1'b0;
          if (snk_sop && !hold) begin
            take = 1'b1;
          end else if (snk_sop || snk_eop) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Common handling of a beat that belongs to a frame, located at pixel index pos.
    if (take) begin
      wren_d = 1'b1;
      addr_d = pos;
      data_d = rgb30_to_rgb444(snk_data);
      if (snk_eop) begin
        state_d = StIdle;
        cnt_d   = '0;
        if (pos == LastIdx) begin
          done_d = 1'b1;
          err_d  = 1'b0;
        end else begin
          err_d  = 1'b1;
          code_d = ERR_SHORT;
        end
      end else if (pos == LastIdx) begin
        state_d      = StDiscard;
        cnt_d        = '0;
        disc_first_d = 1'b1;
      end else begin
        state_d = StActive;
        cnt_d   = pos + ADDR_W'(1);
      end
    end

    if (restart) begin
      err_d  = 1'b1;
      code_d = ERR_RESTART;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      disc_first_q <= 1'b0;
      wren_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      code_q       <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      disc_first_q <= disc_first_d;
      wren_q       <= wren_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      done_q       <= done_d;
      err_q        <= err_d;
      code_q       <= code_d;
    end
  end

  assign wren       = wren_q;
  assign wraddress  = addr_q;
  assign wrdata     = data_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign err_code   = code_q;
  assign busy       = (state_q == StActive);

endmodule
